control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/instr_class_decode.sv | 26 ++
 rtl/control_sequencer.sv | 147 ++++++++++++++
 tb/tb_control_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, IR field positions, sequencer states
// and instruction classes. Optional feature macro: MULDIV_EN.
package cpu_pkg;

  // IR field bit positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int C_MSB  = 18;
  localparam int C_LSB  = 0;

  // Opcode constants
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  // Instruction classes driving the execute-phase sequence
  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps the 5-bit opcode to an instruction class. Without MULDIV_EN,
// mul/div fall into the nop class.
import cpu_pkg::*;

module instr_class_decode (
  input  logic [4:0]   op,
  output instr_class_t instr_class
);

  // Pure opcode-to-class lookup; anything unlisted behaves as a nop
  always_comb begin
    instr_class = CLS_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       instr_class = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:              instr_class = CLS_IMM;
      OP_NEG, OP_NOT:                        instr_class = CLS_UNARY;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV:                        instr_class = CLS_MULDIV;
`endif
      OP_HALT:                               instr_class = CLS_HALT;
      default:                               instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then class-dependent execute
// steps. Optional macro MULDIV_EN enables the T3-T6 mul/div sequence.
import cpu_pkg::*;

module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  opcode,
  output logic        run
);

  state_t       state, next_state;
  instr_class_t instr_class;
  logic [4:0]   op;
  logic         unused_ir;

  assign op        = IR[OP_MSB:OP_LSB];
  assign unused_ir = ^IR[OP_LSB-1:0];

  instr_class_decode u_decode (
    .op          (op),
    .instr_class (instr_class)
  );

  // State register; clear forces the fetch step from any state
  always_ff @(posedge clock) begin
    if (clear) state <= ST_T0;
    else       state <= next_state;
  end

  // Next-state and Moore output decode from state and opcode class
  always_comb begin
    next_state = state;
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    opcode = 5'b00000;
    run = 1'b1;
    case (state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
        next_state = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next_state = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = ST_T3;
      end
      ST_T3: begin
        case (instr_class)
          CLS_RTYPE, CLS_IMM: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            next_state = ST_T4;
          end
          CLS_UNARY: begin
            Grb = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = op;
            next_state = ST_T4;
          end
`ifdef MULDIV_EN
          CLS_MULDIV: begin
            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
            next_state = ST_T4;
          end
`endif
          CLS_HALT: next_state = ST_HALT;
          default:  next_state = ST_T0;
        endcase
      end
      ST_T4: begin
        case (instr_class)
          CLS_RTYPE: begin
            Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = op;
            next_state = ST_T5;
          end
          CLS_IMM: begin
            Cout = 1'b1; ZLowIn = 1'b1; opcode = op;
            next_state = ST_T5;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            next_state = ST_T0;
          end
`ifdef MULDIV_EN
          CLS_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; opcode = op;
            next_state = ST_T5;
          end
`endif
          default: next_state = ST_T0;
        endcase
      end
      ST_T5: begin
`ifdef MULDIV_EN
        if (instr_class == CLS_MULDIV) begin
          Zlowout = 1'b1; LOin = 1'b1;
          next_state = ST_T6;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          next_state = ST_T0;
        end
`else
        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        next_state = ST_T0;
`endif
      end
      ST_T6: begin
`ifdef MULDIV_EN
        Zhighout = 1'b1; HIin = 1'b1;
`endif
        next_state = ST_T0;
      end
      ST_HALT: begin
        run = 1'b0;
        next_state = ST_HALT;
      end
      default: next_state = ST_T0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; expectations follow
// the MULDIV_EN macro when it is defined for the build.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin;
  logic HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Gra, Grb, Grc, Rin, Rout, run;
  logic [4:0] opcode;

  int compared = 0;
  int mismatched = 0;

  localparam logic [26:0] B_PCOUT  = 27'(1) << 26;
  localparam logic [26:0] B_ZHOUT  = 27'(1) << 25;
  localparam logic [26:0] B_ZLOUT  = 27'(1) << 24;
  localparam logic [26:0] B_MDROUT = 27'(1) << 23;
  localparam logic [26:0] B_COUT   = 27'(1) << 22;
  localparam logic [26:0] B_MARIN  = 27'(1) << 21;
  localparam logic [26:0] B_PCIN   = 27'(1) << 20;
  localparam logic [26:0] B_MDRIN  = 27'(1) << 19;
  localparam logic [26:0] B_IRIN   = 27'(1) << 18;
  localparam logic [26:0] B_YIN    = 27'(1) << 17;
  localparam logic [26:0] B_HIIN   = 27'(1) << 16;
  localparam logic [26:0] B_LOIN   = 27'(1) << 15;
  localparam logic [26:0] B_ZHIN   = 27'(1) << 14;
  localparam logic [26:0] B_ZLIN   = 27'(1) << 13;
  localparam logic [26:0] B_INCPC  = 27'(1) << 12;
  localparam logic [26:0] B_READ   = 27'(1) << 11;
  localparam logic [26:0] B_GRA    = 27'(1) << 10;
  localparam logic [26:0] B_GRB    = 27'(1) << 9;
  localparam logic [26:0] B_GRC    = 27'(1) << 8;
  localparam logic [26:0] B_RIN    = 27'(1) << 7;
  localparam logic [26:0] B_ROUT   = 27'(1) << 6;
  localparam logic [26:0] B_RUN    = 27'(1);

  localparam logic [26:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN | B_RUN;
  localparam logic [26:0] E_T1 = B_ZLOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [26:0] E_T2 = B_MDROUT | B_IRIN | B_RUN;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .Cout(Cout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .opcode(opcode), .run(run)
  );

  // Free-running clock
  always #5 clock = ~clock;

  function automatic logic [26:0] obs();
    return {PCout, Zhighout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin,
            Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Gra, Grb, Grc,
            Rin, Rout, opcode, run};
  endfunction

  function automatic logic [26:0] op_field(input logic [4:0] op);
    return {21'b0, op, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds clear for one edge and releases it, leaving the DUT in T0
  task automatic restart();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] seq [3];
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2;
    IR = 32'h0;
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL reset step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
  endtask

  task automatic test_clear_hold();
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (obs() !== E_T0) begin
        mismatched++;
        $display("[TB] FAIL clear_hold cycle %0d: got %h want %h", i, obs(), E_T0);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_rol();
    logic [26:0] seq [7];
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2;
    seq[3] = B_GRB | B_ROUT | B_YIN | B_RUN;
    seq[4] = B_GRC | B_ROUT | B_ZLIN | op_field(5'b01000) | B_RUN;
    seq[5] = B_ZLOUT | B_GRA | B_RIN | B_RUN;
    seq[6] = E_T0;
    IR = 32'h421B8000;
    restart();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL rol step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
  endtask

  task automatic test_addi();
    logic [26:0] seq [7];
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2;
    seq[3] = B_GRB | B_ROUT | B_YIN | B_RUN;
    seq[4] = B_COUT | B_ZLIN | op_field(5'b01100) | B_RUN;
    seq[5] = B_ZLOUT | B_GRA | B_RIN | B_RUN;
    seq[6] = E_T0;
    IR = 32'h6297FFFB;
    restart();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL addi step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
  endtask

  task automatic test_unary();
    logic [26:0] seq [6];
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2;
    seq[3] = B_GRB | B_ROUT | B_ZLIN | op_field(5'b10001) | B_RUN;
    seq[4] = B_ZLOUT | B_GRA | B_RIN | B_RUN;
    seq[5] = E_T0;
    IR = 32'h88800000;
    restart();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL neg step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
  endtask

  task automatic test_nop_illegal();
    logic [26:0] seq [5];
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2;
    seq[3] = B_RUN;
    seq[4] = E_T0;
    IR = 32'h00000000;
    restart();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL ld_as_nop step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [26:0] seq [8];
    int n;
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2;
`ifdef MULDIV_EN
    seq[3] = B_GRA | B_ROUT | B_YIN | B_RUN;
    seq[4] = B_GRB | B_ROUT | B_ZHIN | B_ZLIN | op_field(5'b10000) | B_RUN;
    seq[5] = B_ZLOUT | B_LOIN | B_RUN;
    seq[6] = B_ZHOUT | B_HIIN | B_RUN;
    seq[7] = E_T0;
    n = 8;
`else
    seq[3] = B_RUN;
    seq[4] = E_T0;
    seq[5] = E_T1;
    seq[6] = E_T2;
    seq[7] = B_RUN;
    n = 8;
`endif
    IR = 32'h81180000;
    restart();
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL mul step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [26:0] seq [4];
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2; seq[3] = B_RUN;
    IR = 32'hD8000000;
    restart();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL halt step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      compared++;
      if (obs() !== 27'b0) begin
        mismatched++;
        $display("[TB] FAIL halted cycle %0d: got %h want %h", i, obs(), 27'b0);
      end
    end
    restart();
    compared++;
    if (obs() !== E_T0) begin
      mismatched++;
      $display("[TB] FAIL halt_release: got %h want %h", obs(), E_T0);
    end
  endtask

  task automatic test_abort();
    logic [26:0] seq [3];
    seq[0] = E_T0; seq[1] = E_T1; seq[2] = E_T2;
    IR = 32'h19A10000;
    restart();
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (obs() !== (B_GRC | B_ROUT | B_ZLIN | op_field(5'b00011) | B_RUN)) begin
      mismatched++;
      $display("[TB] FAIL abort_at_t4: got %h want %h", obs(),
               B_GRC | B_ROUT | B_ZLIN | op_field(5'b00011) | B_RUN);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs() !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL abort step %0d: got %h want %h", i, obs(), seq[i]);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    IR = 32'h0;
    test_reset();
    test_clear_hold();
    test_rol();
    test_addi();
    test_unary();
    test_nop_illegal();
    test_mul();
    test_halt();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
